piano_keyboard_renderer: RTL and testbench
==========================================

Name: piano_keyboard_renderer

Overview:
- Pipelined, parametrised keyboard sprite for the projected-piano video path.
- Draws NUM_OCTAVES octaves of keys (7 white and 5 black per octave) at an on-screen origin (x, y).
- Highlights pressed keys, and holds each highlight for a programmable number of frames after release.
- Sits between the XVGA timing generator and the pixel mux. Output pixel is registered with fixed 2-cycle latency.

Parameters:
- NUM_OCTAVES, 2, octaves drawn; keys are indexed chromatically from C of octave 0.
- WHITE_KEY_WIDTH, 90, white key width in pixels (>= BLACK_KEY_WIDTH+2).
- WHITE_KEY_HEIGHT, 300, white key height in pixels.
- BLACK_KEY_WIDTH, 30, black key width in pixels (even).
- BLACK_KEY_HEIGHT, 180, black key height in pixels (< WHITE_KEY_HEIGHT).
- HOLD_FRAMES, 8, frames a highlight persists after release (1..255).
- WHITE_COLOR, 24'hFF_FF_FF, idle white key.
- BLACK_COLOR, 24'h20_20_20, idle black key.
- PRESS_COLOR, 24'h00_C0_FF, highlighted key.
- OUTLINE_COLOR, 24'h00_00_00, key separator (only with KEY_OUTLINE_EN).

Ports:
- vclock input 1: pixel clock.
- reset_n input 1: asynchronous, active-low reset.
- x input 11: keyboard left edge.
- y input 10: keyboard top edge.
- hcount input 11: current pixel column.
- vcount input 10: current pixel row.
- frame_start input 1: one-cycle pulse once per frame.
- key_pressed input 12*NUM_OCTAVES: level per chromatic key; bit 0 = C of octave 0.
- pixel output 24: registered RGB.
- key_index output 7: chromatic index of the key under the pixel, aligned with pixel.
- key_valid output 1: high when pixel lies on a key, aligned with pixel.

Behaviour:
- Reset (reset_n low, asynchronous): pixel=0, key_index=0, key_valid=0; all hold counters and pipeline registers cleared.
- KBD_WIDTH = NUM_OCTAVES*7*WHITE_KEY_WIDTH. All bound compares use 12-bit (h) and 11-bit (v) sums, so x+KBD_WIDTH never wraps.
- Stage 0, column tracker:
  - On hcount==x: col=0, white index w=0.
  - Otherwise, while hcount is inside [x, x+KBD_WIDTH): col increments; when col reaches WHITE_KEY_WIDTH-1 it wraps to 0 and w increments.
  - No divider is used. Any hcount jump (line wrap) is recovered by the reload at hcount==x.
- Region classification, registered at stage 1:
  - in_kbd requires vcount in [y, y+WHITE_KEY_HEIGHT).
  - Let n = w mod 7 (white keys C D E F G A B).
  - Left black: vcount < y+BLACK_KEY_HEIGHT, n in {1,2,4,5,6}, col < BLACK_KEY_WIDTH/2.
  - Right black: same height test, n in {0,1,3,4,5}, col >= WHITE_KEY_WIDTH-BLACK_KEY_WIDTH/2.
  - Black overrides white. Outermost keyboard edges never draw a half black key.
  - Chromatic index: octave*12 + white map {0,2,4,5,7,9,11}[n]. Black left adds -1, black right adds +1.
- Stage 2, registered output:
  - Outside keyboard: pixel=0, key_valid=0, key_index=0.
  - Otherwise colour by key type, replaced by PRESS_COLOR when key highlighted.
  - Latency from hcount/vcount to pixel is exactly 2 vclock cycles.
- Hold counters (8-bit, one per chromatic key):
  - While key_pressed[k]=1: load HOLD_FRAMES.
  - Else, on frame_start: decrement if non-zero.
  - highlighted[k] = key_pressed[k] | (cnt[k]!=0).
  - Press and frame_start in the same cycle: load wins.
  - Counter saturates at 0.
- key_pressed is sampled every cycle and is assumed synchronous to vclock.

Optional Feature:
- KEY_OUTLINE_EN defined: white pixels with col==0 draw OUTLINE_COLOR, key_valid stays 1, black keys are unaffected.
- KEY_OUTLINE_EN undefined: no separators; adjacent white keys are distinguishable only when highlighted.

Decomposition:
- Package piano_pkg holds:
  - WHITE_TO_CHROMA lookup (7 entries).
  - Masks BLACK_LEFT_MASK=7'b1110110 and BLACK_RIGHT_MASK=7'b0111011, bit n = white note.
  - KEYS_PER_OCTAVE=12, WHITES_PER_OCTAVE=7.
  - Colour localparams.
- Sub-module key_hold_timer: one instance per chromatic key via generate; owns the 8-bit counter and the highlight output.

Test Plan (defaults, x=100, y=200):
- hcount=100, vcount=450 -> 2 cycles later pixel=FFFFFF, key_index=0, key_valid=1.
- hcount=185, vcount=250 (C col 85, right black) -> pixel=202020, key_index=1; same column at vcount=400 -> FFFFFF, key_index=0.
- hcount=370, vcount=250 (F col 0, n=3; left black not allowed) -> FFFFFF, key_index=5.
- key_pressed[13]=1 then released:
  - Pixel on octave-1 C# shows 00C0FF.
  - Stays 00C0FF for 8 frame_start pulses after release, FFFFFF-region black 202020 after the 8th.
- Press re-asserted in the same cycle as frame_start while count=1 -> counter reloads to 8, no gap in highlight.
- reset_n pulsed low mid-line -> pixel=0 immediately (asynchronous); first valid pixel 2 cycles after hcount==x following release.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared constants for the piano keyboard renderer: note maps, black-key masks, colours.
package piano_pkg;

    localparam int KEYS_PER_OCTAVE   = 12;
    localparam int WHITES_PER_OCTAVE = 7;
    localparam int HOLD_CNT_W        = 8;

    // Bit n set when white note n (C D E F G A B) carries a black key on that side.
    localparam logic [6:0] BLACK_LEFT_MASK  = 7'b1110110;
    localparam logic [6:0] BLACK_RIGHT_MASK = 7'b0111011;

    localparam logic [6:0][3:0] WHITE_TO_CHROMA = {4'd11, 4'd9, 4'd7, 4'd5, 4'd4, 4'd2, 4'd0};

    localparam logic [23:0] DEF_WHITE_COLOR   = 24'hFF_FF_FF;
    localparam logic [23:0] DEF_BLACK_COLOR   = 24'h20_20_20;
    localparam logic [23:0] DEF_PRESS_COLOR   = 24'h00_C0_FF;
    localparam logic [23:0] DEF_OUTLINE_COLOR = 24'h00_00_00;

endpackage

// File: rtl/piano_keyboard_renderer_key_hold_timer.sv
// Per-key highlight timer: reloads while pressed, counts down on frame_start after release.
module key_hold_timer
    import piano_pkg::*;
#(
    parameter int HOLD_FRAMES = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_pressed,
    input  logic i_frame_start,
    output logic o_highlighted
);

    logic [HOLD_CNT_W-1:0] r_cnt;

    // A press always wins over a simultaneous frame_start so the highlight never gaps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_key_pressed) begin
            r_cnt <= HOLD_CNT_W'(HOLD_FRAMES);
        end else if (i_frame_start && (r_cnt != '0)) begin
            r_cnt <= r_cnt - HOLD_CNT_W'(1);
        end
    end

    assign o_highlighted = i_key_pressed | (r_cnt != '0);

endmodule

// File: rtl/piano_keyboard_renderer.sv
// Pipelined keyboard sprite with per-key highlight hold; pixel lags hcount/vcount by 2 cycles.
// Define KEY_OUTLINE_EN to draw a separator on the first column of every white key.
module piano_keyboard_renderer
    import piano_pkg::*;
#(
    parameter int          NUM_OCTAVES      = 2,
    parameter int          WHITE_KEY_WIDTH  = 90,
    parameter int          WHITE_KEY_HEIGHT = 300,
    parameter int          BLACK_KEY_WIDTH  = 30,
    parameter int          BLACK_KEY_HEIGHT = 180,
    parameter int          HOLD_FRAMES      = 8,
    parameter logic [23:0] WHITE_COLOR      = DEF_WHITE_COLOR,
    parameter logic [23:0] BLACK_COLOR      = DEF_BLACK_COLOR,
    parameter logic [23:0] PRESS_COLOR      = DEF_PRESS_COLOR,
    parameter logic [23:0] OUTLINE_COLOR    = DEF_OUTLINE_COLOR
) (
    input  logic                      vclock,
    input  logic                      reset_n,
    input  logic [10:0]               x,
    input  logic [9:0]                y,
    input  logic [10:0]               hcount,
    input  logic [9:0]                vcount,
    input  logic                      frame_start,
    input  logic [12*NUM_OCTAVES-1:0] key_pressed,
    output logic [23:0]               pixel,
    output logic [6:0]                key_index,
    output logic                      key_valid
);

    localparam int NUM_KEYS   = KEYS_PER_OCTAVE * NUM_OCTAVES;
    localparam int KBD_WIDTH  = NUM_OCTAVES * WHITES_PER_OCTAVE * WHITE_KEY_WIDTH;
    localparam int HALF_BLACK = BLACK_KEY_WIDTH / 2;
    localparam int COL_W      = $clog2(WHITE_KEY_WIDTH);
    localparam int OCT_W      = $clog2(NUM_OCTAVES + 1);
`ifdef KEY_OUTLINE_EN
    localparam bit OUTLINE_ON = 1'b1;
`else
    localparam bit OUTLINE_ON = 1'b0;
`endif

    logic [11:0]      w_hend;
    logic [10:0]      w_vend_white, w_vend_black;
    logic             w_in_h, w_in_v, w_black_v;
    logic [COL_W-1:0] w_col, r_col;
    logic [2:0]       w_n, r_n;
    logic [OCT_W-1:0] w_oct, r_oct;
    logic             w_locked, r_locked;
    logic             w_on_kbd, w_left, w_right;
    logic [6:0]       w_base, w_idx;
    logic             r_on_p1, r_black_p1, r_edge_p1;
    logic [6:0]       r_idx_p1;
    logic [NUM_KEYS-1:0] w_hl;
    logic             w_lit;
    logic [23:0]      w_pix;

    assign w_hend       = {1'b0, x} + 12'(KBD_WIDTH);
    assign w_vend_white = {1'b0, y} + 11'(WHITE_KEY_HEIGHT);
    assign w_vend_black = {1'b0, y} + 11'(BLACK_KEY_HEIGHT);
    assign w_in_h       = ({1'b0, hcount} >= {1'b0, x}) && ({1'b0, hcount} < w_hend);
    assign w_in_v       = ({1'b0, vcount} >= {1'b0, y}) && ({1'b0, vcount} < w_vend_white);
    assign w_black_v    = {1'b0, vcount} < w_vend_black;

    // Stage 0: divider-free column tracker; reloading at hcount==x absorbs any line wrap.
    always_comb begin
        w_col    = r_col;
        w_n      = r_n;
        w_oct    = r_oct;
        w_locked = r_locked;
        if (hcount == x) begin
            w_col    = '0;
            w_n      = '0;
            w_oct    = '0;
            w_locked = 1'b1;
        end else if (w_in_h) begin
            if (r_col == COL_W'(WHITE_KEY_WIDTH - 1)) begin
                w_col = '0;
                if (r_n == 3'd6) begin
                    w_n   = '0;
                    w_oct = r_oct + OCT_W'(1);
                end else begin
                    w_n = r_n + 3'd1;
                end
            end else begin
                w_col = r_col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            r_col    <= '0;
            r_n      <= '0;
            r_oct    <= '0;
            r_locked <= 1'b0;
        end else begin
            r_col    <= w_col;
            r_n      <= w_n;
            r_oct    <= w_oct;
            r_locked <= w_locked;
        end
    end

    assign w_on_kbd = w_locked && w_in_h && w_in_v;
    assign w_left   = w_black_v && BLACK_LEFT_MASK[w_n]  && (w_col <  COL_W'(HALF_BLACK));
    assign w_right  = w_black_v && BLACK_RIGHT_MASK[w_n] && (w_col >= COL_W'(WHITE_KEY_WIDTH - HALF_BLACK));
    assign w_base   = 7'(w_oct) * 7'(KEYS_PER_OCTAVE) + 7'(WHITE_TO_CHROMA[w_n]);
    assign w_idx    = w_left ? (w_base - 7'd1) : (w_right ? (w_base + 7'd1) : w_base);

    // Stage 1: registered region classification.
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            r_on_p1    <= 1'b0;
            r_black_p1 <= 1'b0;
            r_edge_p1  <= 1'b0;
            r_idx_p1   <= '0;
        end else begin
            r_on_p1    <= w_on_kbd;
            r_black_p1 <= w_left | w_right;
            r_edge_p1  <= (w_col == '0);
            r_idx_p1   <= w_idx;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_hold
        key_hold_timer #(.HOLD_FRAMES(HOLD_FRAMES)) u_hold (
            .i_clk         (vclock),
            .i_rst_n       (reset_n),
            .i_key_pressed (key_pressed[k]),
            .i_frame_start (frame_start),
            .o_highlighted (w_hl[k])
        );
    end

    always_comb begin
        w_lit = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (r_idx_p1 == 7'(k)) w_lit = w_hl[k];
        end
    end

    always_comb begin
        w_pix = '0;
        if (r_on_p1) begin
            if (r_black_p1)                   w_pix = w_lit ? PRESS_COLOR : BLACK_COLOR;
            else if (OUTLINE_ON && r_edge_p1) w_pix = OUTLINE_COLOR;
            else                              w_pix = w_lit ? PRESS_COLOR : WHITE_COLOR;
        end
    end

    // Stage 2: registered pixel and key tag.
    always_ff @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            pixel     <= '0;
            key_index <= '0;
            key_valid <= 1'b0;
        end else begin
            pixel     <= w_pix;
            key_index <= r_on_p1 ? r_idx_p1 : 7'd0;
            key_valid <= r_on_p1;
        end
    end

endmodule

// File: tb/tb_piano_keyboard_renderer.sv
// Self-checking bench for piano_keyboard_renderer: behavioural model plus literal probes.
module tb_piano_keyboard_renderer;

    localparam int NO = 2, WKW = 90, WKH = 300, BKW = 30, BKH = 180, HOLD = 8;
    localparam int NK = 12 * NO, KBD = NO * 7 * WKW;
    localparam logic [23:0] C_WHITE = 24'hFFFFFF, C_BLACK = 24'h202020;
    localparam logic [23:0] C_PRESS = 24'h00C0FF, C_OUTL = 24'h000000;
`ifdef KEY_OUTLINE_EN
    localparam bit OUTL = 1'b1;
`else
    localparam bit OUTL = 1'b0;
`endif
    localparam logic [23:0] C_COL0 = OUTL ? C_OUTL : C_WHITE;

    logic          vclock = 1'b0, reset_n = 1'b0;
    logic [10:0]   x = 11'd100, hcount = 11'd0;
    logic [9:0]    y = 10'd200, vcount = 10'd0;
    logic          frame_start = 1'b0;
    logic [NK-1:0] key_pressed = '0;
    logic [23:0]   pixel;
    logic [6:0]    key_index;
    logic          key_valid;

    piano_keyboard_renderer dut (
        .vclock(vclock), .reset_n(reset_n), .x(x), .y(y), .hcount(hcount), .vcount(vcount),
        .frame_start(frame_start), .key_pressed(key_pressed),
        .pixel(pixel), .key_index(key_index), .key_valid(key_valid)
    );

    always #5 vclock = ~vclock;

    int checks = 0, failures = 0, cyc = 0;
    bit chk_en = 1'b0;
    always @(posedge vclock) cyc <= cyc + 1;

    int          white_semi [7] = '{0, 2, 4, 5, 7, 9, 11};
    int          cnt_m [NK];
    bit          hl_m [NK];
    bit          locked_m = 1'b0;
    bit          s1_on = 1'b0, s1_blk = 1'b0, s1_edg = 1'b0;
    int          s1_idx = 0;
    logic [23:0] exp_pix = '0;
    int          exp_idx = 0;
    bit          exp_vld = 1'b0;

    function automatic void classify(input int h, input int v, input int xx, input int yy, input bit lk,
                                     output bit on, output bit blk, output bit edg, output int idx);
        int d, col, w, n;
        d   = h - xx;
        on  = lk && (d >= 0) && (d < KBD) && (v >= yy) && (v < yy + WKH);
        blk = 1'b0; edg = 1'b0; idx = 0;
        if (on) begin
            col = d % WKW; w = d / WKW; n = w % 7;
            idx = (w / 7) * 12 + white_semi[n];
            edg = (col == 0);
            if (v < yy + BKH) begin
                if (col < BKW / 2 && n inside {1, 2, 4, 5, 6}) begin blk = 1'b1; idx = idx - 1; end
                else if (col >= WKW - BKW / 2 && n inside {0, 1, 3, 4, 5}) begin blk = 1'b1; idx = idx + 1; end
            end
        end
    endfunction

    always @(posedge vclock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NK; k++) cnt_m[k] = 0;
            locked_m = 1'b0; s1_on = 1'b0; s1_blk = 1'b0; s1_edg = 1'b0; s1_idx = 0;
            exp_pix = '0; exp_idx = 0; exp_vld = 1'b0;
        end else begin
            for (int k = 0; k < NK; k++) hl_m[k] = key_pressed[k] || (cnt_m[k] != 0);
            if (!s1_on) begin
                exp_pix = '0; exp_idx = 0; exp_vld = 1'b0;
            end else begin
                exp_vld = 1'b1; exp_idx = s1_idx;
                if (s1_blk)              exp_pix = hl_m[s1_idx] ? C_PRESS : C_BLACK;
                else if (OUTL && s1_edg) exp_pix = C_OUTL;
                else                     exp_pix = hl_m[s1_idx] ? C_PRESS : C_WHITE;
            end
            if (hcount == x) locked_m = 1'b1;
            classify(int'(hcount), int'(vcount), int'(x), int'(y), locked_m, s1_on, s1_blk, s1_edg, s1_idx);
            for (int k = 0; k < NK; k++) begin
                if (key_pressed[k])                  cnt_m[k] = HOLD;
                else if (frame_start && cnt_m[k] > 0) cnt_m[k] = cnt_m[k] - 1;
            end
        end
    end

    bit          lit_on = 1'b0;
    int          lit_at = 0, lit_idx = 0;
    logic [23:0] lit_pix = '0;
    bit          lit_vld = 1'b0;
    string       lit_name = "";

    always begin
        @(negedge vclock or negedge reset_n);
        #1;
        if (chk_en) begin
            checks++;
            if (pixel !== exp_pix || key_index !== 7'(exp_idx) || key_valid !== exp_vld) begin
                failures++;
                if (failures <= 30)
                    $display("FAIL model_cmp cyc=%0d h=%0d v=%0d pixel got %h want %h idx got %0d want %0d vld got %0b want %0b",
                             cyc, hcount, vcount, pixel, exp_pix, key_index, exp_idx, key_valid, exp_vld);
            end
            if (!reset_n) begin
                checks++;
                if (pixel !== 24'h0 || key_index !== 7'd0 || key_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_state pixel got %h idx %0d vld %0b want 000000 0 0", pixel, key_index, key_valid);
                end
            end
            if (lit_on && cyc == lit_at) begin
                checks++;
                if (pixel !== lit_pix || key_index !== 7'(lit_idx) || key_valid !== lit_vld) begin
                    failures++;
                    $display("FAIL %s pixel got %h want %h idx got %0d want %0d vld got %0b want %0b",
                             lit_name, pixel, lit_pix, key_index, lit_idx, key_valid, lit_vld);
                end
            end
        end
    end

    // Scan a line from x-3 through h_probe+2 and pin the output produced for h_probe.
    task automatic scan_to(input int h_probe, input int v, input logic [23:0] ep, input int ei,
                           input bit ev, input string nm);
        vcount = 10'(v);
        for (int hc = int'(x) - 3; hc <= h_probe + 2; hc++) begin
            @(negedge vclock);
            if (hc == h_probe) begin
                lit_pix = ep; lit_idx = ei; lit_vld = ev; lit_name = nm;
                lit_at = cyc + 2; lit_on = 1'b1;
            end
            hcount = 11'(hc);
        end
        @(negedge vclock);
        hcount = x - 11'd3;
    endtask

    task automatic pulse_frame();
        @(negedge vclock); frame_start = 1'b1;
        @(negedge vclock); frame_start = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge vclock);
        chk_en = 1'b1;
        @(negedge vclock); reset_n = 1'b1;

        scan_to(100,  450, C_COL0,  0,  1'b1, "white_c_first_col");
        scan_to(185,  250, C_BLACK, 1,  1'b1, "c_sharp_right_black");
        scan_to(185,  400, C_WHITE, 0,  1'b1, "c_below_black");
        scan_to(370,  250, C_COL0,  5,  1'b1, "f_no_left_black");
        scan_to(1359, 250, C_WHITE, 23, 1'b1, "last_white_b_edge");
        scan_to(1360, 250, 24'h0,   0,  1'b0, "right_of_kbd");
        scan_to(150,  500, 24'h0,   0,  1'b0, "below_kbd");

        @(negedge vclock); key_pressed[13] = 1'b1;
        scan_to(810, 250, C_PRESS, 13, 1'b1, "press_c_sharp_oct1");
        key_pressed[13] = 1'b0;
        scan_to(810, 250, C_PRESS, 13, 1'b1, "hold_after_release");
        for (int i = 1; i <= HOLD; i++) begin
            pulse_frame();
            if (i < HOLD) scan_to(810, 250, C_PRESS, 13, 1'b1, $sformatf("hold_frame_%0d", i));
            else          scan_to(810, 250, C_BLACK, 13, 1'b1, "hold_expired");
        end

        @(negedge vclock); key_pressed[13] = 1'b1;
        @(negedge vclock); key_pressed[13] = 1'b0;
        repeat (HOLD - 1) pulse_frame();
        @(negedge vclock); key_pressed[13] = 1'b1; frame_start = 1'b1;
        @(negedge vclock); key_pressed[13] = 1'b0; frame_start = 1'b0;
        repeat (HOLD - 1) pulse_frame();
        scan_to(810, 250, C_PRESS, 13, 1'b1, "reload_no_gap");
        pulse_frame();
        scan_to(810, 250, C_BLACK, 13, 1'b1, "reload_expire");

        key_pressed[2] = 1'b1;
        vcount = 10'd250;
        for (int hc = 97; hc <= 700; hc++) begin
            @(negedge vclock);
            hcount = 11'(hc);
            if (hc == 403) reset_n = 1'b1;
            if (hc == 400) begin #2; reset_n = 1'b0; end
        end
        @(negedge vclock); hcount = x - 11'd3; key_pressed = '0;
        scan_to(100, 450, C_COL0, 0, 1'b1, "first_valid_after_reset");

        for (int ln = 0; ln < 20; ln++) begin
            int nx, ny, nv;
            nx = $urandom_range(3, 2047 - KBD - 4);
            ny = $urandom_range(0, 700);
            nv = ny - 10 + $urandom_range(0, WKH + 20);
            if (nv < 0) nv = 0;
            if (nv > 1023) nv = 1023;
            for (int hc = nx - 3; hc < nx + KBD + 3; hc++) begin
                @(negedge vclock);
                if (hc == nx - 3) begin
                    x = 11'(nx); y = 10'(ny); vcount = 10'(nv);
                    key_pressed = NK'($urandom) & NK'($urandom);
                end
                hcount = 11'(hc);
                frame_start = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 99) == 0) begin
                    int kk;
                    kk = $urandom_range(0, NK - 1);
                    key_pressed[kk] = ~key_pressed[kk];
                end
            end
        end
        @(negedge vclock); frame_start = 1'b0;
        repeat (3) @(negedge vclock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
